// File: rtl/opto_cycle_pkg.sv
// Shared types and constants for the opto cycle monitor.
// The FSM state encoding, fixed RAM addresses and the read latency live here.
package opto_cycle_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_CNT   = 3'd1,
        S_RD_TEETH = 3'd2,
        S_RD_REV   = 3'd3,
        S_EVAL     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [5:0] ADDR_CNT   = 6'd0;
    localparam logic [5:0] ADDR_REV   = 6'd63;
    localparam int         RAM_RD_LAT = 1;

    // Unsigned magnitude of a difference.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/opto_cycle_acc.sv
// Min/max (and optional saturating sum) tracker for tooth cycle words.
// Optional feature macro: CYCLE_MON_SUM_CHECK_EN enables the sum accumulator.
module opto_cycle_acc (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_vld,
    input  logic [31:0] i_data,
    output logic [31:0] o_min,
    output logic [31:0] o_max,
    output logic [31:0] o_sum
);

    logic [31:0] r_min;
    logic [31:0] r_max;

    // Track min/max; clear restarts a scan (min at all-ones so a zero word still wins).
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_min <= 32'hFFFF_FFFF;
            r_max <= 32'h0000_0000;
        end else if (i_vld) begin
            if (i_data < r_min) r_min <= i_data;
            if (i_data > r_max) r_max <= i_data;
        end
    end

    assign o_min = r_min;
    assign o_max = r_max;

`ifdef CYCLE_MON_SUM_CHECK_EN
    logic [31:0] r_sum;

    // Add with clamp at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Saturating accumulation of all tooth words in the scan.
    always_ff @(posedge i_clk) begin
        if (i_clr)      r_sum <= 32'h0000_0000;
        else if (i_vld) r_sum <= sat_add(r_sum, i_data);
    end

    assign o_sum = r_sum;
`else
    assign o_sum = 32'h0000_0000;
`endif

endmodule

// File: rtl/opto_cycle_monitor.sv
// Opto cycle monitor: scans the statistics RAM (count, tooth cycles, revolution
// cycles), evaluates speed/consistency and publishes registered results.
// Optional feature macro: CYCLE_MON_SUM_CHECK_EN (sum-vs-revolution check).
module opto_cycle_monitor #(
    parameter int EXP_OPTO     = 60,
    parameter int SPREAD_SHIFT = 3
) (
    input  logic        i_clk_50m,
    input  logic        i_rst,
    input  logic        i_scan_start,
    input  logic [31:0] i_rev_min,
    input  logic [31:0] i_rev_max,
    output logic [5:0]  o_ram_raddr,
    output logic        o_ram_ren,
    input  logic [31:0] i_ram_rdata,
    output logic [7:0]  o_opto_cnt,
    output logic [31:0] o_min_cycle,
    output logic [31:0] o_max_cycle,
    output logic [31:0] o_rev_cycle,
    output logic [31:0] o_sum_cycle,
    output logic        o_stat_valid,
    output logic        o_busy,
    output logic        o_speed_ok,
    output logic        o_cnt_err,
    output logic        o_sum_err
);

    import opto_cycle_pkg::*;

    localparam logic [5:0] LAST_TOOTH = 6'(EXP_OPTO - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ram_ren;
    logic        w_ren_nxt;
    logic [5:0]  r_ram_raddr;
    logic [5:0]  w_raddr_nxt;
    logic        w_acc_clr;
    logic        w_eval;
    logic        w_done;

    logic [RAM_RD_LAT-1:0] r_rd_vld;
    logic [5:0]            r_rd_addr [RAM_RD_LAT];
    logic                  w_rd_vld;
    logic [5:0]            w_rd_addr;
    logic                  w_cnt_hit;
    logic                  w_tooth_hit;
    logic                  w_rev_hit;

    logic [7:0]  r_cnt;
    logic [31:0] r_rev;
    logic [23:0] w_unused_rdata_hi;

    logic [31:0] w_min;
    logic [31:0] w_max;
    logic [31:0] w_sum;
    logic [31:0] w_tol;
    logic [31:0] w_spread;
    logic        w_sum_err;

    logic        r_cnt_err_e;
    logic        r_rng_ok_e;
    logic        r_spr_ok_e;
    logic        r_sum_err_e;

    logic [7:0]  r_opto_cnt;
    logic [31:0] r_min_cycle;
    logic [31:0] r_max_cycle;
    logic [31:0] r_rev_cycle;
    logic [31:0] r_sum_cycle;
    logic        r_stat_valid;
    logic        r_speed_ok;
    logic        r_cnt_err;
    logic        r_sum_err;

    // State and RAM read port registers.
    always_ff @(posedge i_clk_50m or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ram_ren   <= 1'b0;
            r_ram_raddr <= 6'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ram_ren   <= w_ren_nxt;
            r_ram_raddr <= w_raddr_nxt;
        end
    end

    // Next state, next read request and per-state strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_ren_nxt   = 1'b0;
        w_raddr_nxt = 6'd0;
        w_acc_clr   = 1'b0;
        w_eval      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_scan_start) begin
                    w_state_nxt = S_RD_CNT;
                    w_ren_nxt   = 1'b1;
                    w_raddr_nxt = ADDR_CNT;
                    w_acc_clr   = 1'b1;
                end
            end
            S_RD_CNT: begin
                w_state_nxt = S_RD_TEETH;
                w_ren_nxt   = 1'b1;
                w_raddr_nxt = 6'd1;
            end
            S_RD_TEETH: begin
                w_ren_nxt = 1'b1;
                if (r_ram_raddr == LAST_TOOTH) begin
                    w_raddr_nxt = ADDR_REV;
                    w_state_nxt = S_RD_REV;
                end else begin
                    w_raddr_nxt = r_ram_raddr + 6'd1;
                end
            end
            S_RD_REV: begin
                // Wait here until the revolution word has been captured.
                if (w_rev_hit) w_state_nxt = S_EVAL;
            end
            S_EVAL: begin
                w_eval      = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read-data tag pipeline: marks which address the current rdata belongs to.
    always_ff @(posedge i_clk_50m or posedge i_rst) begin
        if (i_rst) begin
            r_rd_vld <= '0;
        end else begin
            r_rd_vld[0] <= r_ram_ren;
            for (int i = 1; i < RAM_RD_LAT; i++) r_rd_vld[i] <= r_rd_vld[i-1];
        end
    end

    // Address tags ride along with the valid bits.
    always_ff @(posedge i_clk_50m) begin
        r_rd_addr[0] <= r_ram_raddr;
        for (int i = 1; i < RAM_RD_LAT; i++) r_rd_addr[i] <= r_rd_addr[i-1];
    end

    assign w_rd_vld    = r_rd_vld[RAM_RD_LAT-1];
    assign w_rd_addr   = r_rd_addr[RAM_RD_LAT-1];
    assign w_cnt_hit   = w_rd_vld && (w_rd_addr == ADDR_CNT);
    assign w_rev_hit   = w_rd_vld && (w_rd_addr == ADDR_REV);
    assign w_tooth_hit = w_rd_vld && (w_rd_addr >= 6'd1) && (w_rd_addr <= LAST_TOOTH);

    // Only the low byte of the count word is meaningful.
    assign w_unused_rdata_hi = i_ram_rdata[31:8];

    // Capture count and revolution words as they return from RAM.
    always_ff @(posedge i_clk_50m) begin
        if (w_cnt_hit) r_cnt <= i_ram_rdata[7:0];
        if (w_rev_hit) r_rev <= i_ram_rdata;
    end

    opto_cycle_acc u_acc (
        .i_clk  (i_clk_50m),
        .i_clr  (w_acc_clr),
        .i_vld  (w_tooth_hit),
        .i_data (i_ram_rdata),
        .o_min  (w_min),
        .o_max  (w_max),
        .o_sum  (w_sum)
    );

    assign w_tol    = r_rev >> SPREAD_SHIFT;
    assign w_spread = w_max - w_min;

`ifdef CYCLE_MON_SUM_CHECK_EN
    assign w_sum_err = (abs_diff(w_sum, r_rev) > w_tol);
`else
    assign w_sum_err = 1'b0;
`endif

    // EVAL: form the individual verdicts; rev bounds are sampled here.
    always_ff @(posedge i_clk_50m) begin
        if (w_eval) begin
            r_cnt_err_e <= (r_cnt != 8'(EXP_OPTO));
            r_rng_ok_e  <= (i_rev_min <= r_rev) && (r_rev <= i_rev_max);
            r_spr_ok_e  <= (w_spread <= w_tol);
            r_sum_err_e <= w_sum_err;
        end
    end

    // DONE: publish all results together with the one-cycle valid pulse.
    always_ff @(posedge i_clk_50m or posedge i_rst) begin
        if (i_rst) begin
            r_opto_cnt   <= 8'd0;
            r_min_cycle  <= 32'd0;
            r_max_cycle  <= 32'd0;
            r_rev_cycle  <= 32'd0;
            r_sum_cycle  <= 32'd0;
            r_stat_valid <= 1'b0;
            r_speed_ok   <= 1'b0;
            r_cnt_err    <= 1'b0;
            r_sum_err    <= 1'b0;
        end else begin
            r_stat_valid <= w_done;
            if (w_done) begin
                r_opto_cnt  <= r_cnt;
                r_min_cycle <= w_min;
                r_max_cycle <= w_max;
                r_rev_cycle <= r_rev;
                r_sum_cycle <= w_sum;
                r_cnt_err   <= r_cnt_err_e;
                r_sum_err   <= r_sum_err_e;
                r_speed_ok  <= !r_cnt_err_e && r_rng_ok_e && r_spr_ok_e && !r_sum_err_e;
            end
        end
    end

    assign o_ram_ren    = r_ram_ren;
    assign o_ram_raddr  = r_ram_raddr;
    assign o_busy       = (r_state != S_IDLE);
    assign o_opto_cnt   = r_opto_cnt;
    assign o_min_cycle  = r_min_cycle;
    assign o_max_cycle  = r_max_cycle;
    assign o_rev_cycle  = r_rev_cycle;
    assign o_sum_cycle  = r_sum_cycle;
    assign o_stat_valid = r_stat_valid;
    assign o_speed_ok   = r_speed_ok;
    assign o_cnt_err    = r_cnt_err;
    assign o_sum_err    = r_sum_err;

endmodule

// File: tb/tb_opto_cycle_monitor.sv
// Self-checking bench for opto_cycle_monitor with a behavioural RAM and result model.
// Honours CYCLE_MON_SUM_CHECK_EN the same way the design does.
module tb_opto_cycle_monitor;

    localparam int EXP = 60;
    localparam int SH  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] rmin, rmax, rdata;
    logic [5:0]  raddr;
    logic        ren;
    logic [7:0]  opto_cnt;
    logic [31:0] min_c, max_c, rev_c, sum_c;
    logic        stat_valid, busy, speed_ok, cnt_err, sum_err;

    logic [31:0] mem [64];
    logic [5:0]  rd_q [$];

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [7:0]  e_cnt;
    logic [31:0] e_min, e_max, e_rev, e_sum;
    logic        e_cnt_err, e_sum_err, e_ok;

    opto_cycle_monitor #(.EXP_OPTO(EXP), .SPREAD_SHIFT(SH)) dut (
        .i_clk_50m    (clk),
        .i_rst        (rst),
        .i_scan_start (start),
        .i_rev_min    (rmin),
        .i_rev_max    (rmax),
        .o_ram_raddr  (raddr),
        .o_ram_ren    (ren),
        .i_ram_rdata  (rdata),
        .o_opto_cnt   (opto_cnt),
        .o_min_cycle  (min_c),
        .o_max_cycle  (max_c),
        .o_rev_cycle  (rev_c),
        .o_sum_cycle  (sum_c),
        .o_stat_valid (stat_valid),
        .o_busy       (busy),
        .o_speed_ok   (speed_ok),
        .o_cnt_err    (cnt_err),
        .o_sum_err    (sum_err)
    );

    always #10 clk = ~clk;

    // RAM with one-cycle read latency; data is garbage whenever no read was issued.
    always @(posedge clk) begin
        if (ren) begin
            rdata <= mem[raddr];
            rd_q.push_back(raddr);
        end else begin
            rdata <= $urandom();
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected results straight from the rules: min/max/sum over teeth, flag formulas.
    task automatic model();
        longint unsigned s;
        logic [31:0] tol, diff;
        s = 0; e_min = 32'hFFFF_FFFF; e_max = 32'h0;
        for (int a = 1; a < EXP; a++) begin
            s += longint'(mem[a]);
            if (mem[a] < e_min) e_min = mem[a];
            if (mem[a] > e_max) e_max = mem[a];
        end
        e_cnt = mem[0][7:0];
        e_rev = mem[63];
        tol   = e_rev >> SH;
`ifdef CYCLE_MON_SUM_CHECK_EN
        e_sum     = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
        diff      = (e_sum >= e_rev) ? e_sum - e_rev : e_rev - e_sum;
        e_sum_err = (diff > tol);
`else
        diff      = 32'h0;
        e_sum     = 32'h0;
        e_sum_err = 1'b0;
`endif
        e_cnt_err = (e_cnt != 8'(EXP));
        e_ok = !e_cnt_err && (e_rev >= rmin) && (e_rev <= rmax)
               && ((e_max - e_min) <= tol) && !e_sum_err;
    endtask

    task automatic fill(input logic [31:0] cnt, input logic [31:0] tooth, input logic [31:0] rev);
        mem[0] = cnt;
        for (int a = 1; a < 64; a++) mem[a] = (a < EXP) ? tooth : $urandom();
        mem[63] = rev;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".outs"}, 32'(|{opto_cnt, min_c, max_c, rev_c, sum_c, speed_ok, cnt_err, sum_err}), 32'd0);
        check({tag, ".ctl"}, 32'({stat_valid, busy, ren, raddr}), 32'd0);
    endtask

    // One scan from the current (mid-cycle) time; dup_at>0 re-pulses start at T+dup_at.
    task automatic scan(input string tag, input int dup_at);
        int first, pulses, seq_err;
        logic [5:0] ea;
        first = 0; pulses = 0; seq_err = 0;
        model();
        rd_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 90; k++) begin
            start = (k == dup_at);
            @(posedge clk); #1;
            if (stat_valid) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        start = 1'b0;
        check({tag, ".lat"},    first,  64);
        check({tag, ".pulses"}, pulses, 1);
        check({tag, ".idle"},   32'(busy), 32'd0);
        check({tag, ".cnt"},    32'(opto_cnt), 32'(e_cnt));
        check({tag, ".min"},    min_c, e_min);
        check({tag, ".max"},    max_c, e_max);
        check({tag, ".rev"},    rev_c, e_rev);
        check({tag, ".sum"},    sum_c, e_sum);
        check({tag, ".cnt_err"},  32'(cnt_err),  32'(e_cnt_err));
        check({tag, ".sum_err"},  32'(sum_err),  32'(e_sum_err));
        check({tag, ".speed_ok"}, 32'(speed_ok), 32'(e_ok));
        check({tag, ".nreads"}, rd_q.size(), EXP + 1);
        for (int i = 0; i < rd_q.size(); i++) begin
            ea = (i == 0) ? 6'd0 : (i == EXP) ? 6'd63 : 6'(i);
            if (rd_q[i] !== ea) seq_err++;
        end
        check({tag, ".rdseq"}, seq_err, 0);
    endtask

    initial begin
        int unsigned base, jit, s, rev, tol;
        int pulses;
        rst = 1'b1; start = 1'b0; rmin = 32'd0; rmax = 32'd0;
        fill(32'd60, 32'd1000, 32'd59000);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal revolution.
        rmin = 32'd50000; rmax = 32'd70000;
        fill(32'd60, 32'd1000, 32'd59000);
        scan("nominal", 0);

        // Short count; upper bits of the count word set to prove they are ignored.
        fill(32'hABCD_EF3B, 32'd1000, 32'd59000);
        scan("cnt59", 0);
        fill(32'h5A5A_A53C, 32'd1000, 32'd59000);
        scan("cnt_hi_bits", 0);

        // Spread just inside, then just outside tolerance.
        fill(32'd60, 32'd1000, 32'd67000); mem[17] = 32'd9000;
        scan("spread_ok", 0);
        fill(32'd60, 32'd1000, 32'd68000); mem[17] = 32'd10000;
        scan("spread_bad", 0);

        // Spread exactly at tolerance (and sum diff exactly at tolerance), then one over.
        fill(32'd60, 32'd1000, 32'd59000); mem[40] = 32'd8375;
        scan("spread_eq", 0);
        fill(32'd60, 32'd1000, 32'd59000); mem[40] = 32'd8376;
        scan("spread_eq1", 0);

        // Sum against revolution, rev sitting on the inclusive lower bound.
        fill(32'd60, 32'd1000, 32'd50000);
        scan("sum_check", 0);

        // Revolution exactly on, then one past, the upper bound.
        rmin = 32'd50000; rmax = 32'd59000;
        fill(32'd60, 32'd1000, 32'd59000);
        scan("rev_eq_max", 0);
        rmax = 32'd58999;
        scan("rev_over_max", 0);

        // Zero tooth word and saturating sum.
        rmin = 32'd0; rmax = 32'hFFFF_FFFF;
        fill(32'd60, 32'd100, 32'd5900); mem[5] = 32'd0;
        scan("tooth_zero", 0);
        fill(32'd60, 32'h1000_0000, 32'hFFFF_FFFF);
        scan("saturate", 0);

        // Start repeated while busy.
        rmin = 32'd50000; rmax = 32'd70000;
        fill(32'd60, 32'd1000, 32'd59000);
        scan("dup_start", 10);

        // Reset in the middle of a scan.
        fill(32'd60, 32'd1200, 32'd70800);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #5 rst = 1'b1;
        #1 check_outputs_zero("mid_rst");
        @(posedge clk); @(posedge clk); #1;
        check_outputs_zero("mid_rst_hold");
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (stat_valid) pulses++;
        end
        check("mid_rst.no_valid", pulses, 0);
        fill(32'd60, 32'd1000, 32'd59000);
        scan("after_rst", 0);

        // Randomised revolutions.
        for (int n = 0; n < 8; n++) begin
            base = $urandom_range(4000, 200);
            jit  = $urandom_range(base / 4, 0);
            s = 0;
            for (int a = 1; a < 64; a++) begin
                mem[a] = (a < EXP) ? base + $urandom_range(jit, 0) : $urandom();
                if ($urandom_range(20, 0) == 0 && a < EXP) mem[a] = 32'd0;
                if (a < EXP) s += mem[a];
            end
            tol  = s >> SH;
            rev  = s + $urandom_range(2 * tol, 0) - tol;
            mem[63] = rev;
            mem[0]  = ($urandom() & 32'hFFFF_FF00) |
                      (($urandom_range(3, 0) == 0) ? $urandom_range(65, 55) : 32'd60);
            rmin = rev - 1000 + $urandom_range(1200, 0);
            rmax = rev + 1000 - $urandom_range(1200, 0);
            scan("random", 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
